// File: rtl/iir_coeff_ctrl.sv
// -----------------------------------------------------------------------------
// iir_coeff_ctrl
// Coefficient controller for the biquad IIR filter. A shadow bank is written
// by the control interface or filled from a 4-entry preset ROM; the shadow is
// copied into the active bank in one edge on a sample boundary, so the filter
// never sees a mixed coefficient set. Coefficients are Q2.14 signed.
//
// Optional build macro: STABILITY_CHECK_EN
//   When defined, a swap is refused (commit_err pulses) if shadow a1/a2 lie
//   outside the biquad stability triangle. When undefined, commit_err is 0.
//
// Ports:
//   clk           system clock
//   reset         asynchronous reset, active-high
//   sample_strobe one-cycle pulse per audio sample boundary
//   wr_en         write one shadow coefficient
//   wr_addr       0=b0 1=b1 2=b2 3=a1 4=a2 (5-7 illegal)
//   wr_data       coefficient value to write
//   commit        request shadow-to-active swap
//   preset_sel    preset index for preset_load
//   preset_load   copy selected preset into the shadow bank
//   b0..a2        active coefficients (registered)
//   pending       commit accepted, waiting for sample_strobe
//   busy          preset load in progress
//   commit_done   one-cycle pulse after a swap
//   commit_err    one-cycle pulse after a rejected swap
//   wr_err        one-cycle pulse after an illegal write or request
// -----------------------------------------------------------------------------
module iir_coeff_ctrl #(
    parameter int COEFF_W     = 16,
    parameter int NUM_PRESETS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_strobe,
    input  logic               wr_en,
    input  logic [2:0]         wr_addr,
    input  logic [COEFF_W-1:0] wr_data,
    input  logic               commit,
    input  logic [1:0]         preset_sel,
    input  logic               preset_load,
    output logic [COEFF_W-1:0] b0,
    output logic [COEFF_W-1:0] b1,
    output logic [COEFF_W-1:0] b2,
    output logic [COEFF_W-1:0] a1,
    output logic [COEFF_W-1:0] a2,
    output logic               pending,
    output logic               busy,
    output logic               commit_done,
    output logic               commit_err,
    output logic               wr_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PENDING = 2'd2
    } state_t;

    // Preset ROM lookup: {sel, idx} -> coefficient; unlisted entries are zero.
    function automatic logic [COEFF_W-1:0] rom_f(input logic [1:0] sel, input logic [2:0] idx);
        logic [COEFF_W-1:0] val;
        val = {COEFF_W{1'b0}};
        if (int'(sel) < NUM_PRESETS) begin
            case ({sel, idx})
                5'b00_000: val = COEFF_W'(16'sd16384);
                5'b01_000: val = COEFF_W'(16'sd15871);
                5'b01_001: val = COEFF_W'(-16'sd30917);
                5'b01_010: val = COEFF_W'(16'sd15106);
                5'b01_011: val = COEFF_W'(-16'sd30906);
                5'b01_100: val = COEFF_W'(16'sd14618);
                5'b11_000: val = COEFF_W'(16'sd8192);
                default:   val = {COEFF_W{1'b0}};
            endcase
        end else begin
            val = {COEFF_W{1'b0}};
        end
        return val;
    endfunction

`ifdef STABILITY_CHECK_EN
    // Stability triangle in Q2.14: -1 < a2 < 1 and |a1| < 1 + a2.
    // 18-bit intermediates hold |a1| up to 32768 and 1 + a2 up to 49151.
    function automatic logic stable_f(input logic [COEFF_W-1:0] a1_v, input logic [COEFF_W-1:0] a2_v);
        logic signed [17:0] a1_x;
        logic signed [17:0] a2_x;
        logic signed [17:0] abs_a1;
        logic signed [17:0] lim;
        a1_x   = 18'($signed(a1_v));
        a2_x   = 18'($signed(a2_v));
        abs_a1 = (a1_x < 18'sd0) ? -a1_x : a1_x;
        lim    = 18'sd16384 + a2_x;
        return (a2_x > -18'sd16384) && (a2_x < 18'sd16384) && (abs_a1 < lim);
    endfunction
`endif

    state_t             state_r, state_s;
    logic [2:0]         idx_r, idx_s;
    logic [1:0]         sel_r, sel_s;
    logic [COEFF_W-1:0] shadow_r [5];
    logic [COEFF_W-1:0] active_r [5];
    logic               sh_we_s;
    logic [2:0]         sh_idx_s;
    logic [COEFF_W-1:0] sh_val_s;
    logic               swap_s;
    logic               wr_err_s;
    logic               pending_r;
    logic               busy_r;
    logic               commit_done_r;
    logic               wr_err_r;
`ifdef STABILITY_CHECK_EN
    logic               reject_s;
    logic               commit_err_r;
`endif

    // Next-state, shadow write port and event decode.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        sel_s    = sel_r;
        sh_we_s  = 1'b0;
        sh_idx_s = 3'd0;
        sh_val_s = {COEFF_W{1'b0}};
        swap_s   = 1'b0;
        wr_err_s = 1'b0;
`ifdef STABILITY_CHECK_EN
        reject_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                // A write in the same cycle as commit lands first and is swapped.
                if (wr_en) begin
                    if (wr_addr <= 3'd4) begin
                        sh_we_s  = 1'b1;
                        sh_idx_s = wr_addr;
                        sh_val_s = wr_data;
                    end else begin
                        wr_err_s = 1'b1;
                    end
                end else begin
                    sh_we_s = 1'b0;
                end
                // preset_load has priority over commit; the dropped commit is an error.
                if (preset_load) begin
                    state_s = LOAD;
                    idx_s   = 3'd0;
                    sel_s   = preset_sel;
                    if (commit) begin
                        wr_err_s = 1'b1;
                    end else begin
                        sel_s = preset_sel;
                    end
                end else if (commit) begin
                    state_s = PENDING;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                sh_we_s  = 1'b1;
                sh_idx_s = idx_r;
                sh_val_s = rom_f(sel_r, idx_r);
                if (idx_r == 3'd4) begin
                    state_s = IDLE;
                    idx_s   = 3'd0;
                end else begin
                    idx_s = idx_r + 3'd1;
                end
                if (wr_en || commit || preset_load) begin
                    wr_err_s = 1'b1;
                end else begin
                    wr_err_s = 1'b0;
                end
            end
            PENDING: begin
                // A repeated commit is harmless and silently absorbed.
                if (wr_en || preset_load) begin
                    wr_err_s = 1'b1;
                end else begin
                    wr_err_s = 1'b0;
                end
                if (sample_strobe) begin
                    state_s = IDLE;
`ifdef STABILITY_CHECK_EN
                    if (stable_f(shadow_r[3], shadow_r[4])) begin
                        swap_s = 1'b1;
                    end else begin
                        reject_s = 1'b1;
                    end
`else
                    swap_s = 1'b1;
`endif
                end else begin
                    state_s = PENDING;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, load index and latched preset selection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= 3'd0;
            sel_r   <= 2'd0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            sel_r   <= sel_s;
        end
    end

    // Shadow and active banks; reset value is unity passthrough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) begin
                shadow_r[i] <= (i == 0) ? COEFF_W'(16'sd16384) : {COEFF_W{1'b0}};
                active_r[i] <= (i == 0) ? COEFF_W'(16'sd16384) : {COEFF_W{1'b0}};
            end
        end else begin
            if (sh_we_s) begin
                shadow_r[sh_idx_s] <= sh_val_s;
            end
            if (swap_s) begin
                for (int i = 0; i < 5; i++) begin
                    active_r[i] <= shadow_r[i];
                end
            end
        end
    end

    // Registered status flags and event pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r     <= 1'b0;
            busy_r        <= 1'b0;
            commit_done_r <= 1'b0;
            wr_err_r      <= 1'b0;
        end else begin
            pending_r     <= (state_s == PENDING);
            busy_r        <= (state_s == LOAD);
            commit_done_r <= swap_s;
            wr_err_r      <= wr_err_s;
        end
    end

`ifdef STABILITY_CHECK_EN
    // Rejected-swap pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_err_r <= 1'b0;
        end else begin
            commit_err_r <= reject_s;
        end
    end
    assign commit_err = commit_err_r;
`else
    assign commit_err = 1'b0;
`endif

    assign b0          = active_r[0];
    assign b1          = active_r[1];
    assign b2          = active_r[2];
    assign a1          = active_r[3];
    assign a2          = active_r[4];
    assign pending     = pending_r;
    assign busy        = busy_r;
    assign commit_done = commit_done_r;
    assign wr_err      = wr_err_r;

endmodule
